// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_pkg
//  Description : Shared L1 instruction-cache types and sizing constants used by
//                the lookup, array and refill logic.
//  Revision    : 1.0 - initial release with refill controller types
// ============================================================================
package memory_pkg;

    localparam int ICACHE_L1_ASSOCIATIVITY = 4;
    localparam int ICACHE_L1_SETS          = 64;
    localparam int ICACHE_L1_TAG_WIDTH     = 20;
    localparam int ICACHE_LINE_WIDTH       = 128;
    localparam int ICACHE_L1_IDX_WIDTH     = $clog2(ICACHE_L1_SETS);

    typedef logic [ICACHE_L1_TAG_WIDTH-1:0]     icache_L1_tag_t;
    typedef logic [ICACHE_LINE_WIDTH-1:0]       icache_line_t;
    typedef logic [ICACHE_L1_ASSOCIATIVITY-1:0] icache_hit_vec_t;
    typedef logic [ICACHE_L1_IDX_WIDTH-1:0]     icache_L1_idx_t;
    typedef logic [ICACHE_L1_TAG_WIDTH+ICACHE_L1_IDX_WIDTH-1:0] icache_line_addr_t;

    // Refill controller states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_SWEEP = 3'd4
    } icache_refill_state_t;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/icache_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module      : icache_victim_sel
//  Description : Replacement-way chooser. Picks the lowest-index invalid way;
//                when the whole set is valid, falls back to a round-robin
//                pointer that only moves when a valid way is replaced.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_victim_sel
    import memory_pkg::*;
#(
    parameter int N_WAY = ICACHE_L1_ASSOCIATIVITY,
    localparam int PTR_W = $clog2(N_WAY)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [N_WAY-1:0] valid_vec_i,
    input  logic             advance_i,
    output logic [N_WAY-1:0] victim_o,
    output logic             all_valid_o
);

    logic [PTR_W-1:0] rr_ptr;

    // Round-robin pointer: steps (with wrap) each time a valid way is evicted.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance_i) begin
            if (rr_ptr == PTR_W'(N_WAY - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= rr_ptr + PTR_W'(1);
            end
        end
    end

    // First-invalid priority encoder with round-robin fallback, one-hot out.
    always_comb begin
        logic found;
        victim_o    = '0;
        found       = 1'b0;
        all_valid_o = &valid_vec_i;
        for (int i = 0; i < N_WAY; i++) begin
            if (!found && !valid_vec_i[i]) begin
                victim_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
        if (!found) begin
            victim_o = N_WAY'(1) << rr_ptr;
        end
    end

endmodule : icache_victim_sel
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : L1 icache refill / invalidation controller. Fetches missing
//                lines from L2, writes tag/data/valid into the chosen victim
//                way, and sweeps every set to clear valid bits after reset
//                and on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import memory_pkg::*;
#(
    parameter int N_WAY  = ICACHE_L1_ASSOCIATIVITY,
    parameter int N_SETS = ICACHE_L1_SETS,
    localparam int IDX_W = $clog2(N_SETS)
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    // lookup side
    input  logic                           miss_i,
    input  icache_L1_tag_t                 miss_tag_i,
    input  logic [IDX_W-1:0]               miss_idx_i,
    input  logic [N_WAY-1:0]               valid_vec_i,
    input  logic                           flush_i,
    output logic                           busy_o,
    // L2 request channel
    output logic                           l2_req_valid_o,
    input  logic                           l2_req_ready_i,
    output logic [ICACHE_L1_TAG_WIDTH+IDX_W-1:0] l2_req_addr_o,
    // L2 answer channel
    input  logic                           l2_ans_valid_i,
    output logic                           l2_ans_ready_o,
    input  icache_line_t                   l2_ans_line_i,
    // array write port
    output logic                           wr_en_o,
    output logic [N_WAY-1:0]               wr_way_o,
    output logic [IDX_W-1:0]               wr_idx_o,
    output icache_L1_tag_t                 wr_tag_o,
    output icache_line_t                   wr_line_o,
    output logic                           wr_valid_o,
    output logic                           refill_done_o
);

    icache_refill_state_t state, state_nxt;

    icache_L1_tag_t     tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N_WAY-1:0]   way_q;
    logic               way_was_valid_q;
    icache_line_t       line_q;
    logic               flush_pend;
    logic [IDX_W-1:0]   sweep_cnt;

    logic               sweep_last;
    logic               flush_now;
    logic               accept_miss;
    logic [N_WAY-1:0]   victim;
    logic               all_valid;
    logic               rr_advance;

    assign sweep_last  = (sweep_cnt == IDX_W'(N_SETS - 1));
    // A flush arriving in the same cycle as a miss still takes priority.
    assign flush_now   = flush_pend | flush_i;
    assign accept_miss = (state == ST_IDLE) && miss_i && !flush_now;
    assign rr_advance  = (state == ST_WRITE) && way_was_valid_q;

    icache_victim_sel #(
        .N_WAY (N_WAY)
    ) u_victim_sel (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .valid_vec_i (valid_vec_i),
        .advance_i   (rr_advance),
        .victim_o    (victim),
        .all_valid_o (all_valid)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush_now) begin
                    state_nxt = ST_SWEEP;
                end else if (miss_i) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (l2_req_ready_i) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (l2_ans_valid_i) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_nxt = flush_pend ? ST_SWEEP : ST_IDLE;
            end
            ST_SWEEP: begin
                if (sweep_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Miss context and returned line; held until the refill write.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tag_q           <= '0;
            idx_q           <= '0;
            way_q           <= '0;
            way_was_valid_q <= 1'b0;
            line_q          <= '0;
        end else begin
            if (accept_miss) begin
                tag_q           <= miss_tag_i;
                idx_q           <= miss_idx_i;
                way_q           <= victim;
                way_was_valid_q <= all_valid;
            end
            if ((state == ST_WAIT) && l2_ans_valid_i) begin
                line_q <= l2_ans_line_i;
            end
        end
    end

    // Pending-flush flag and sweep counter; a new flush beats the clear.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b1;
            sweep_cnt  <= '0;
        end else begin
            if (flush_i) begin
                flush_pend <= 1'b1;
            end else if ((state == ST_SWEEP) && sweep_last) begin
                flush_pend <= 1'b0;
            end
            if (state == ST_SWEEP) begin
                sweep_cnt <= sweep_last ? '0 : sweep_cnt + IDX_W'(1);
            end
        end
    end

    // Output decode from registered state and latched data only.
    always_comb begin
        busy_o         = (state != ST_IDLE);
        l2_req_valid_o = 1'b0;
        l2_req_addr_o  = '0;
        l2_ans_ready_o = 1'b0;
        wr_en_o        = 1'b0;
        wr_way_o       = '0;
        wr_idx_o       = '0;
        wr_tag_o       = '0;
        wr_line_o      = '0;
        wr_valid_o     = 1'b0;
        refill_done_o  = 1'b0;
        case (state)
            ST_REQ: begin
                l2_req_valid_o = 1'b1;
                l2_req_addr_o  = {tag_q, idx_q};
            end
            ST_WAIT: begin
                l2_ans_ready_o = 1'b1;
            end
            ST_WRITE: begin
                wr_en_o       = 1'b1;
                wr_way_o      = way_q;
                wr_idx_o      = idx_q;
                wr_tag_o      = tag_q;
                wr_line_o     = line_q;
                wr_valid_o    = 1'b1;
                refill_done_o = 1'b1;
            end
            ST_SWEEP: begin
                wr_en_o  = 1'b1;
                wr_way_o = '1;
                wr_idx_o = sweep_cnt;
            end
            default: ;
        endcase
    end

endmodule : icache_refill_ctrl
`default_nettype wire
